// File: rtl/llr_cb_popper_pkg.sv
// Shared rate-dematching constants, drain FSM states and the lane-mask helper.
// The packing FIFO reuses lane_mask to qualify partial pops.
package llr_cb_popper_pkg;

    localparam int unsigned LLR_W  = 6;
    localparam int unsigned LANES  = 32;
    localparam int unsigned ELEN_W = 16;
    localparam int unsigned BUS_W  = LANES * LLR_W;
    localparam int unsigned CNT_W  = $clog2(LANES);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    // Mask that keeps lanes 0..cnt (cnt is a count minus one).
    function automatic logic [BUS_W-1:0] lane_mask(input logic [CNT_W-1:0] cnt);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i <= 32'(cnt)) begin
                m[i*LLR_W +: LLR_W] = '1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/llr_cb_popper_if.sv
// Configuration, FIFO pop and output-beat signals of the code-block drain stage.
// slave is the popper side, master the environment driving it.
interface llr_cb_popper_if
    import llr_cb_popper_pkg::*;
();

    logic              cfg_start;
    logic [ELEN_W-1:0] cfg_e_len;
    logic [CNT_W-1:0]  cfg_chunk;
    logic              o_pop_permit;
    logic [CNT_W-1:0]  o_pop_amout;
    logic              i_pop_enable;
    logic [BUS_W-1:0]  i_pop_data;
    logic [BUS_W-1:0]  o_llr_data;
    logic [CNT_W-1:0]  o_llr_cnt;
    logic              o_llr_valid;
    logic              i_llr_ready;
    logic              o_sop;
    logic              o_eop;
    logic              o_busy;
    logic              o_done;

    modport slave (
        input  cfg_start, cfg_e_len, cfg_chunk, i_pop_enable, i_pop_data, i_llr_ready,
        output o_pop_permit, o_pop_amout, o_llr_data, o_llr_cnt, o_llr_valid, o_sop, o_eop,
               o_busy, o_done
    );

    modport master (
        output cfg_start, cfg_e_len, cfg_chunk, i_pop_enable, i_pop_data, i_llr_ready,
        input  o_pop_permit, o_pop_amout, o_llr_data, o_llr_cnt, o_llr_valid, o_sop, o_eop,
               o_busy, o_done
    );

endinterface

// File: rtl/llr_cb_popper_out_stage.sv
// One-deep registered output slot: loads a beat, holds it until accepted.
// A load in the accept cycle replaces the old beat without a bubble.
module llr_cb_popper_out_stage
    import llr_cb_popper_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic [BUS_W-1:0] data_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             sop_i,
    input  logic             eop_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [BUS_W-1:0] data_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sop_o,
    output logic             eop_o
);

    logic             valid_q, valid_d;
    logic [BUS_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            cnt_d   = cnt_i;
            sop_d   = sop_i;
            eop_d   = eop_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;

endmodule

// File: rtl/llr_cb_popper.sv
// Drains exactly E LLRs per code block from the packing FIFO in chunks of up to 32,
// shortening the final chunk so the FIFO is never popped past the block boundary.
module llr_cb_popper
    import llr_cb_popper_pkg::*;
(
    input  logic           i_core_clk,
    input  logic           i_rx_rstn,
    llr_cb_popper_if.slave bus
);

    state_e            state_q, state_d;
    logic [ELEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]  chunk_q, chunk_d;
    logic              first_q, first_d;
    logic              done_q, done_d;

    logic [ELEN_W-1:0] rem_m1;
    logic [ELEN_W-1:0] take;
    logic [CNT_W-1:0]  amout;
    logic              permit, pop, last_pop, accept_eop;
    logic              out_valid, out_eop;

    assign rem_m1   = rem_q - ELEN_W'(1);
    assign amout    = (rem_m1 < ELEN_W'(chunk_q)) ? rem_m1[CNT_W-1:0] : chunk_q;
    assign take     = ELEN_W'(amout) + ELEN_W'(1);
    assign permit   = (state_q == StRun) && (!out_valid || bus.i_llr_ready);
    assign pop      = permit && bus.i_pop_enable;
    assign last_pop = (rem_q == take);
    assign accept_eop = out_valid && out_eop && bus.i_llr_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        chunk_d = chunk_q;
        first_d = first_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.cfg_start) begin
                    if (bus.cfg_e_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        rem_d   = bus.cfg_e_len;
                        chunk_d = bus.cfg_chunk;
                        first_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (pop) begin
                    rem_d   = rem_q - take;
                    first_d = 1'b0;
                    if (last_pop) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (accept_eop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            state_q <= StIdle;
            rem_q   <= '0;
            chunk_q <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            chunk_q <= chunk_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    llr_cb_popper_out_stage u_out_stage (
        .clk_i   (i_core_clk),
        .rstn_i  (i_rx_rstn),
        .load_i  (pop),
        .data_i  (bus.i_pop_data & lane_mask(amout)),
        .cnt_i   (amout),
        .sop_i   (first_q),
        .eop_i   (last_pop),
        .ready_i (bus.i_llr_ready),
        .valid_o (out_valid),
        .data_o  (bus.o_llr_data),
        .cnt_o   (bus.o_llr_cnt),
        .sop_o   (bus.o_sop),
        .eop_o   (out_eop)
    );

    assign bus.o_llr_valid  = out_valid;
    assign bus.o_eop        = out_eop;
    assign bus.o_pop_permit = permit;
    assign bus.o_pop_amout  = amout;
    assign bus.o_busy       = (state_q != StIdle);
    assign bus.o_done       = done_q;

endmodule
